// File: rtl/spart_rx.sv
// spart_rx: SPART receive engine. Oversamples rxd on rx_tick, validates the
// start bit, shifts in DATA_BITS data bits LSB-first and checks the stop bit.
// The byte and its rda / frame_err / overrun flags go to the bus-side logic.
// Optional feature macro: SPART_RX_MAJORITY_EN. When defined, each bit is
// decided by a 2-of-3 vote over three consecutive mid-bit ticks.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low on a tick
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling data bits at one-bit intervals
// STOP  | sampling the stop bit, then completing the frame
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_tick,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          dec_cnt;
  logic                   at_dec;
  logic                   bit_val;
  logic                   frame_done;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign at_dec = (tick_q == dec_cnt);

  // Metastability chain on rxd; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= (sync_q << 1) | SYNC_STAGES'(rxd);
  end

`ifdef SPART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_TWO  = TW'(2);
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);

  logic [1:0] vote_q, vote_d;

  // The start decision moves one tick later (mid+1); data and stop decisions stay
  // one bit period apart from it, so the vote window stays centred on each bit.
  always_comb begin
    dec_cnt = (state_q == START) ? START_DEC : BIT_END;
    bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
    vote_d  = vote_q;
    if (rx_tick && (state_q != IDLE)) begin
      if (tick_q == (dec_cnt - TICK_TWO)) vote_d[0] = rxs;
      if (tick_q == (dec_cnt - TICK_ONE)) vote_d[1] = rxs;
    end
  end

  // Holds the two earlier samples of the 3-sample vote.
  always_ff @(posedge clk) begin
    if (!rst) vote_q <= 2'b11;
    else      vote_q <= vote_d;
  end
`else
  // Single sample at the bit centre.
  always_comb begin
    dec_cnt = (state_q == START) ? MID_CNT : BIT_END;
    bit_val = rxs;
  end
`endif

  // FSM state, tick/bit counters and shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; everything advances only on rx_tick.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    if (rx_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (at_dec) begin
            if (!bit_val) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        DATA: begin
          if (at_dec) begin
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BIT_ONE;
            if (bit_q == LAST_BIT) state_d = STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        STOP: begin
          if (at_dec) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            tick_d     = '0;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus-side buffer and flags; a read coinciding with completion makes room for the new byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rd && rda) begin
        rda       <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (frame_done) begin
        if (!rda || rd) begin
          rx_data <= shift_q;
          rda     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        if (!bit_val) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Testbench for spart_rx: table of frames plus hand sequences for reset,
// latency, false start, overrun, break and glitch cases, then random frames
// against a flag/buffer model. Honours SPART_RX_MAJORITY_EN if defined.
module tb_spart_rx;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk
`ifdef SPART_RX_MAJORITY_EN
  localparam int MAJ_EXTRA = 4;
`else
  localparam int MAJ_EXTRA = 0;
`endif
  // Frames start on the negedge just before a tick edge (P1). With the 2-flop
  // synchroniser the start is seen at P5, its centre sample is at P37 and the
  // centre of data bit k observes rxd at P(99+64k); the stop decision lands at
  // P613 (one tick later with the 3-sample vote).
  localparam int EXP_RISE  = 9 * BIT_CLKS + 37 + MAJ_EXTRA;
  localparam int GLITCH_AT = 98;

  logic       clk = 1'b0;
  logic       rst, rxd, rx_tick, rd;
  logic [7:0] rx_data;
  logic       rda, frame_err, overrun;

  int checks = 0;
  int failures = 0;
  int tick_phase = 0;
  int rise, l_ref, l2;

  logic [7:0] m_data;
  logic       m_rda, m_fe, m_ov;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd_after;
    logic [7:0] e_data;
    logic       e_rda;
    logic       e_fe;
    logic       e_ov;
  } vec_t;
  vec_t tbl[7];

  spart_rx dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_tick(rx_tick), .rd(rd),
    .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    rx_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick_phase = (tick_phase + 1) % 4;
      rx_tick = (tick_phase == 0);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic r, input logic fe, input logic ov);
    chk({tag, ".rx_data"}, {24'd0, rx_data}, {24'd0, d});
    chk({tag, ".rda"}, {31'd0, rda}, {31'd0, r});
    chk({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, fe});
    chk({tag, ".overrun"}, {31'd0, overrun}, {31'd0, ov});
  endtask

  task automatic align_tick();
    int n = 0;
    @(negedge clk);
    while (!rx_tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rx_tick) chk("tick_align", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit,
                            input int rd_cyc, input int ncyc, output int rise_cyc);
    logic prev, b;
    int idx;
    align_tick();
    prev = rda;
    rise_cyc = -1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      idx = cyc / BIT_CLKS;
      if (idx == 0)      b = 1'b0;
      else if (idx <= 8) b = data[idx-1];
      else               b = stop;
      if (glitch_bit >= 0 && cyc == GLITCH_AT + BIT_CLKS * glitch_bit) b = ~b;
      rxd = b;
      rd  = (cyc == rd_cyc);
      @(negedge clk);
      if (rda && !prev && rise_cyc < 0) rise_cyc = cyc + 1;
      prev = rda;
    end
    rd = 1'b0;
  endtask

  task automatic idle(input int n, input int rd_at);
    rxd = 1'b1;
    for (int cyc = 0; cyc < n; cyc++) begin
      rd = (cyc == rd_at);
      @(negedge clk);
    end
    rd = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Receive buffer as seen from the bus: one slot plus three sticky flags.
  task automatic model_step(input logic rd_now, input logic done, input logic [7:0] d, input logic stop);
    logic [7:0] n_data;
    logic n_rda, n_fe, n_ov;
    n_data = m_data; n_rda = m_rda; n_fe = m_fe; n_ov = m_ov;
    if (rd_now && m_rda) begin
      n_rda = 1'b0; n_fe = 1'b0; n_ov = 1'b0;
    end
    if (done) begin
      if (!m_rda || rd_now) begin
        n_data = d;
        n_rda  = 1'b1;
      end else begin
        n_ov = 1'b1;
      end
      if (!stop) n_fe = 1'b1;
    end
    m_data = n_data; m_rda = n_rda; m_fe = n_fe; m_ov = n_ov;
  endtask

  initial begin
    logic [7:0] d;
    logic       s, co, g;

    tbl[0] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    // Reset with the line low and ticks running.
    rst = 1'b0; rxd = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(200, -1);
    chk_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic frame with latency measurement.
    send_frame(8'hAA, 1'b1, -1, -1, 10 * BIT_CLKS, rise);
    chk("basic.rx_data", {24'd0, rx_data}, 32'hAA);
    chk("basic.rda", {31'd0, rda}, 32'd1);
    chk($sformatf("basic.latency rise=%0d", rise),
        {31'd0, (rise >= EXP_RISE - 1 && rise <= EXP_RISE + 1)}, 32'd1);
    l_ref = (rise > 0) ? rise : EXP_RISE;
    idle(80, -1);
    pulse_rd();
    chk("basic.rd_clears_rda", {31'd0, rda}, 32'd0);

    // False start: 3-tick low glitch.
    align_tick();
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle(200, -1);
    chk("false_start.rda", {31'd0, rda}, 32'd0);
    chk("false_start.frame_err", {31'd0, frame_err}, 32'd0);
    send_frame(8'h55, 1'b1, -1, -1, 10 * BIT_CLKS, rise);
    idle(80, -1);
    chk_out("after_false_start", 8'h55, 1'b1, 1'b0, 1'b0);
    pulse_rd();

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, -1, -1, 10 * BIT_CLKS, rise);
      idle(80, -1);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].e_data, tbl[i].e_rda, tbl[i].e_fe, tbl[i].e_ov);
      if (tbl[i].rd_after) begin
        pulse_rd();
        chk_out($sformatf("tbl[%0d].rd", i), tbl[i].e_data, 1'b0, 1'b0, 1'b0);
      end
    end

    // Overrun, then read exactly on the completing cycle.
    send_frame(8'h11, 1'b1, -1, -1, 10 * BIT_CLKS, rise);
    idle(80, -1);
    send_frame(8'h22, 1'b1, -1, -1, 10 * BIT_CLKS, rise);
    idle(80, -1);
    chk_out("overrun", 8'h11, 1'b1, 1'b0, 1'b1);
    pulse_rd();
    chk("overrun.rd_clears", {31'd0, overrun}, 32'd0);
    send_frame(8'h11, 1'b1, -1, -1, 10 * BIT_CLKS, l2);
    idle(80, -1);
    chk("rerun.rx_data", {24'd0, rx_data}, 32'h11);
    if (l2 < 0) l2 = EXP_RISE;
    send_frame(8'h22, 1'b1, -1, l2 - 1, 10 * BIT_CLKS, rise);
    chk_out("rd_on_completion", 8'h22, 1'b1, 1'b0, 1'b0);
    idle(80, -1);
    pulse_rd();
    chk("rd_on_completion.clear", {31'd0, rda}, 32'd0);

    // Break: line held low past a full frame, then released.
    send_frame(8'h00, 1'b0, -1, -1, 10 * BIT_CLKS + 100, rise);
    chk_out("break", 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1100, -1);
    chk_out("break_rearm", 8'h00, 1'b1, 1'b1, 1'b1);

    // Reset after bit 3 of 0xF0.
    send_frame(8'hF0, 1'b1, -1, -1, 5 * BIT_CLKS, rise);
    rxd = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1400, -1);
    chk_out("mid_reset_after", 8'h00, 1'b0, 1'b0, 1'b0);

    // Random frames against the buffer model.
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom_range(0, 255));
      s  = ($urandom_range(0, 4) != 0);
      co = ($urandom_range(0, 5) == 0);
      g  = ($urandom_range(0, 2) == 0);
      send_frame(d, s, -1, co ? l_ref - 1 : -1, 10 * BIT_CLKS, rise);
      model_step(co, 1'b1, d, s);
      idle(80 + $urandom_range(0, 120), g ? 10 : -1);
      if (g) model_step(1'b1, 1'b0, 8'h00, 1'b1);
      chk_out($sformatf("rand[%0d] d=%0h s=%0b", i, d, s), m_data, m_rda, m_fe, m_ov);
    end

    // Single-sample glitch at the centre of bit 2 of 0xA5.
    pulse_rd();
    send_frame(8'hA5, 1'b1, 2, -1, 10 * BIT_CLKS, rise);
    idle(80, -1);
`ifdef SPART_RX_MAJORITY_EN
    chk("glitch.rx_data", {24'd0, rx_data}, 32'hA5);
`else
    chk("glitch.rx_data", {24'd0, rx_data}, 32'hA1);
`endif
    chk("glitch.rda", {31'd0, rda}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive engine of the SPART; sits directly downstream of the rxd pin and upstream of the SPART bus interface.
- Oversamples the serial rxd line using a baud enable tick from the SPART baud generator.
- Detects and validates start bits, then shifts in 8N1 frames LSB-first.
- Presents the received byte plus rda, framing-error and overrun flags to the bus-side register logic.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, rx_tick pulses per bit period; must be even and at least 4.
- SYNC_STAGES, 2, flip-flop stages on rxd for metastability protection.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- rxd  input  1  serial receive line; idle high.
- rx_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate, from the baud generator.
- rd  input  1  bus-side read strobe (iocs and read of the receive buffer); one clk pulse.
- rx_data  output  DATA_BITS  last accepted byte.
- rda  output  1  received data available.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; a byte completed while rda was already 1.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE, tick and bit counters=0, shift register=0.
  - rx_data=0, rda=0, frame_err=0, overrun=0.
  - Synchronizer stages loaded with 1.
  - Reset mid-frame abandons the frame; no partial byte is ever delivered.
- rxd passes through SYNC_STAGES flops; rxs is the synchronized value. All FSM activity advances only on cycles with rx_tick==1, except the rd handling.
- FSM:
  - IDLE: on a tick with rxs==0, go to START and clear tick_cnt.
  - START: count ticks. At tick_cnt==OVERSAMPLE/2-1, sample rxs.
    - If 0: go to DATA with tick_cnt=0 and bit_cnt=0.
    - If 1: false start; return to IDLE with no flag change.
  - DATA: at tick_cnt==OVERSAMPLE-1, sample rxs into the shift register MSB and shift right (LSB-first reception). Then increment bit_cnt and clear tick_cnt. After DATA_BITS samples, go to STOP.
  - STOP: at tick_cnt==OVERSAMPLE-1, sample the stop bit and complete the frame, then return to IDLE.
- Frame completion, in the clk cycle of the stop sample:
  - rda=0 or rd==1: rx_data <= shift register; rda <= 1.
  - rda=1 and rd==0: overrun <= 1; rx_data and rda are unchanged (new byte discarded).
  - Stop bit sampled 0: frame_err <= 1 and the byte is still delivered under the rules above.
- Latency: rx_data and rda update on the clk edge following the stop-bit sample tick.
- rd handling:
  - rd==1 clears rda, frame_err and overrun on the next clk edge.
  - If rd==1 coincides with a frame completion, the new byte is loaded and rda remains 1.
  - rd with rda==0 has no effect.
- rx_tick==0 freezes the FSM and counters. rd is still honoured.
- A continuously low rxd (break) gives frame_err=1 with rx_data=0x00. The FSM then re-arms from IDLE on the next tick and treats the still-low line as a new start bit.

Optional Feature:
- Macro: SPART_RX_MAJORITY_EN.
- Defined: each start, data and stop bit decision is the 2-of-3 majority of rxs at mid-bit ticks mid-1, mid and mid+1. For data and stop bits, mid = OVERSAMPLE/2-1 counted from the bit boundary. The bit boundary is therefore offset so sampling stays centred; the decision is taken at tick mid+1.
- Undefined: a single sample at the centre point as specified in Behaviour. No extra registers are added.
- Frame timing to rda is unchanged in bit periods whether or not the macro is defined.

Test Plan:
- Reset: hold rst=0 for 3 cycles with rxd=0 and ticks running -> rx_data=0x00, rda=0, frame_err=0, overrun=0, FSM stays IDLE. Release -> reception begins only at the next start bit.
- Basic frame: rx_tick every 4 clk, OVERSAMPLE=16. Drive 0xAA as 8N1 (start 0, bits 0,1,0,1,0,1,0,1, stop 1) -> rda=1 and rx_data=0xAA within 1 clk of the stop sample. Pulse rd -> rda=0 the next cycle.
- False start: 3-tick low glitch on idle rxd -> no rda, no frame_err. A following 0x55 frame is received correctly.
- Framing error: send 0x3C with stop bit 0 -> rx_data=0x3C, rda=1, frame_err=1. rd clears both.
- Overrun: send 0x11 with no read, then 0x22 -> rx_data=0x11, overrun=1. Repeat with rd asserted exactly on the second completion cycle -> rx_data=0x22, rda=1, overrun=0.
- Reset mid-frame and majority vote: assert rst after bit 3 of 0xF0 -> all outputs 0 and no byte delivered. With SPART_RX_MAJORITY_EN, flip a single mid-bit sample of 0xA5 -> 0xA5 is still received. Without the macro, the same glitch corrupts that bit.
